// File: rtl/ma_pkg.sv
// ma_pkg: shared constants and FSM state encoding for the moving-average
// sample streamer.
//   MA_DATA_W       sample / result width
//   MA_FIFO_AW      log2 of sample FIFO depth
//   MA_FILTER_POWER log2 of the averager tap count (16 taps)
//   MA_TIMEOUT      cycles allowed in WAIT_DONE before a sample is abandoned
package ma_pkg;

   localparam int MA_DATA_W       = 10;
   localparam int MA_FIFO_AW      = 3;
   localparam int MA_FILTER_POWER = 4;
   localparam int MA_TIMEOUT      = 31;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_DONE = 2'b01,
      ST_CAPTURE   = 2'b11
   } state_e;

endpackage

// File: rtl/ma_sample_streamer_if.sv
// ma_sample_streamer_if: bundles the three channels around the streamer.
//   sample in : s_data, s_valid -> s_ready, fifo_level
//   filter    : ma_data_o, ma_strobe_o -> ma_done_i, ma_avg_i
//   result    : r_data, r_valid -> r_ready
//   status    : busy, timeout_o
// The streamer connects through the slave modport; the surrounding logic
// (sample source, averager core, result consumer) uses master.
interface ma_sample_streamer_if
   import ma_pkg::*;
#(
   parameter int DATA_W  = MA_DATA_W,
   parameter int FIFO_AW = MA_FIFO_AW
);

   logic [DATA_W-1:0]  s_data;
   logic               s_valid;
   logic               s_ready;
   logic [FIFO_AW:0]   fifo_level;
   logic [DATA_W-1:0]  ma_data_o;
   logic               ma_strobe_o;
   logic               ma_done_i;
   logic [DATA_W-1:0]  ma_avg_i;
   logic [DATA_W-1:0]  r_data;
   logic               r_valid;
   logic               r_ready;
   logic               busy;
   logic               timeout_o;

   modport slave (
      input  s_data, s_valid, ma_done_i, ma_avg_i, r_ready,
      output s_ready, fifo_level, ma_data_o, ma_strobe_o,
             r_data, r_valid, busy, timeout_o
   );

   modport master (
      output s_data, s_valid, ma_done_i, ma_avg_i, r_ready,
      input  s_ready, fifo_level, ma_data_o, ma_strobe_o,
             r_data, r_valid, busy, timeout_o
   );

endinterface

// File: rtl/ma_sync_fifo.sv
// ma_sync_fifo: single-clock FIFO, depth 2**FIFO_AW, async active-high reset.
//   push/din  write request and data (ignored when full)
//   pop/dout  read request (ignored when empty); dout shows the head
//   full, empty, level  occupancy flags and count 0..depth
// No pass-through: full is based on the stored count only, so a pop in the
// same cycle does not make room for a push.
module ma_sync_fifo
   import ma_pkg::*;
#(
   parameter int DATA_W  = MA_DATA_W,
   parameter int FIFO_AW = MA_FIFO_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [FIFO_AW:0]  level
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == (FIFO_AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ma_sample_streamer.sv
// ma_sample_streamer: queues samples, hands them one at a time to the
// moving-average core with a one-cycle strobe, waits for its done strobe and
// captures the average into a valid/ready result register. A filter that
// never answers is abandoned after TIMEOUT cycles.
//   clk, reset  clock, async active-high reset
//   bus         ma_sample_streamer_if.slave (sample, filter, result, status)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no sample in flight; dispatch when FIFO non-empty and the
//            | result register is free or being drained this cycle
// ST_WAIT_DONE | sample presented; strobe high on first cycle; wait for done
// ST_CAPTURE | average valid on ma_avg_i this cycle; load result register
module ma_sample_streamer
   import ma_pkg::*;
#(
   parameter int DATA_W  = MA_DATA_W,
   parameter int FIFO_AW = MA_FIFO_AW,
   parameter int TIMEOUT = MA_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   ma_sample_streamer_if.slave bus
);

   localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_e             state;
   state_e             state_nxt;
   logic [TMR_W-1:0]   timer;
   logic [DATA_W-1:0]  ma_data;
   logic               ma_strobe;
   logic [DATA_W-1:0]  r_data;
   logic               r_valid;
   logic               timeout_pulse;
   logic [DATA_W-1:0]  fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               dispatch;
   logic               capture;
   logic               abandon;

   ma_sync_fifo #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.s_valid),
      .pop   (dispatch),
      .din   (bus.s_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (bus.fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Done is ignored during the strobe cycle; the filter has not yet seen
   // the sample. Done beats the timeout when both land in the same cycle.
   always_comb begin
      state_nxt = state;
      dispatch  = 1'b0;
      capture   = 1'b0;
      abandon   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && (!r_valid || bus.r_ready)) begin
               dispatch  = 1'b1;
               state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.ma_done_i && !ma_strobe) begin
               state_nxt = ST_CAPTURE;
            end else if (timer == TMR_W'(TIMEOUT)) begin
               abandon   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            capture   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ma_data is only loaded on dispatch, so it stays put through WAIT_DONE,
   // CAPTURE (the filter shifts it in on its done cycle) and IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer         <= '0;
         ma_data       <= '0;
         ma_strobe     <= 1'b0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         ma_strobe     <= dispatch;
         timeout_pulse <= abandon;
         if (dispatch) begin
            ma_data <= fifo_dout;
            timer   <= '0;
         end else if (state == ST_WAIT_DONE) begin
            timer <= timer + 1'b1;
         end
         if (capture) begin
            r_data  <= bus.ma_avg_i;
            r_valid <= 1'b1;
         end else if (r_valid && bus.r_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.s_ready     = !fifo_full;
   assign bus.ma_data_o   = ma_data;
   assign bus.ma_strobe_o = ma_strobe;
   assign bus.r_data      = r_data;
   assign bus.r_valid     = r_valid;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.timeout_o   = timeout_pulse;

endmodule

// File: tb/tb_ma_sample_streamer.sv
// tb_ma_sample_streamer: directed scenarios plus a randomized phase against a
// cycle-level reference model (sample queue + transaction phase) and a
// behavioural 16-tap averager that answers a configurable number of cycles
// after each strobe.
module tb_ma_sample_streamer;
   import ma_pkg::*;

   localparam int DW = MA_DATA_W;
   localparam int TO = MA_TIMEOUT;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ma_sample_streamer_if bus();

   ma_sample_streamer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // reference model
   logic [DW-1:0] rq[$];
   int            ph = 0;      // 0 idle, 1 waiting for done, 2 capturing
   int            tst = 0;     // cycle of the strobe for the sample in flight
   logic [DW-1:0] e_data = '0;
   logic [DW-1:0] e_rdata = '0;
   bit            e_strobe = 0, e_tmo = 0, e_rvalid = 0;

   // filter model
   int            fl_t = -1000;
   int            fl_dly = 17;  // 0: never answers
   bit            fl_rand = 0;
   bit            fl_fix_en = 0;
   logic [DW-1:0] fl_fix = '0;
   bit            extra_done = 0;
   bit            done_on_strobe = 0;
   logic [DW-1:0] hist[$];
   logic [DW-1:0] strobe_log[$];

   function automatic logic [DW-1:0] hist_avg();
      int s = 0;
      foreach (hist[i]) s += int'(hist[i]);
      return DW'(s >> MA_FILTER_POWER);
   endfunction

   task automatic ref_step();
      int sz;
      bit push, disp;
      sz   = rq.size();
      push = bus.s_valid && (sz < 8);
      disp = (ph == 0) && (sz > 0) && (!e_rvalid || bus.r_ready);
      e_strobe = 0;
      e_tmo    = 0;
      if (e_rvalid && bus.r_ready) e_rvalid = 0;
      case (ph)
         0: if (disp) begin
               e_data = rq.pop_front();
               e_strobe = 1;
               ph = 1;
               tst = cyc + 1;
            end
         1: if (bus.ma_done_i && cyc != tst) ph = 2;
            else if (cyc - tst == TO) begin
               e_tmo = 1;
               ph = 0;
            end
         default: begin
            e_rvalid = 1;
            e_rdata  = bus.ma_avg_i;
            ph = 0;
         end
      endcase
      if (push) rq.push_back(bus.s_data);
      if (reset) begin
         rq.delete();
         ph = 0; e_data = '0; e_rdata = '0;
         e_strobe = 0; e_tmo = 0; e_rvalid = 0;
      end
   endtask

   task automatic compare();
      check_eq("s_ready",    32'(bus.s_ready),     32'(rq.size() < 8));
      check_eq("fifo_level", 32'(bus.fifo_level),  32'(rq.size()));
      check_eq("ma_strobe",  32'(bus.ma_strobe_o), 32'(e_strobe));
      check_eq("ma_data",    32'(bus.ma_data_o),   32'(e_data));
      check_eq("r_valid",    32'(bus.r_valid),     32'(e_rvalid));
      check_eq("r_data",     32'(bus.r_data),      32'(e_rdata));
      check_eq("busy",       32'(bus.busy),        32'(ph != 0));
      check_eq("timeout",    32'(bus.timeout_o),   32'(e_tmo));
   endtask

   task automatic filter_drive();
      if (bus.ma_strobe_o) begin
         fl_t = cyc;
         if (fl_rand) fl_dly = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 6));
         hist.push_back(bus.ma_data_o);
         if (hist.size() > 16) void'(hist.pop_front());
         strobe_log.push_back(bus.ma_data_o);
      end
      bus.ma_done_i = (fl_dly != 0 && cyc == fl_t + fl_dly) || extra_done
                      || (done_on_strobe && bus.ma_strobe_o);
      if (fl_dly != 0 && cyc == fl_t + fl_dly + 1)
         bus.ma_avg_i = fl_fix_en ? fl_fix : hist_avg();
      else
         bus.ma_avg_i = DW'($urandom);
   endtask

   task automatic tick();
      ref_step();
      @(posedge clk);
      #1;
      cyc++;
      compare();
      filter_drive();
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_strobe(input int max, output int t);
      int n = 0;
      while (!bus.ma_strobe_o && n < max) begin tick(); n++; end
      if (!bus.ma_strobe_o) check_eq("wait_strobe_expired", 32'd0, 32'd1);
      t = cyc;
   endtask

   task automatic wait_rvalid(input int max, output int t);
      int n = 0;
      while (!bus.r_valid && n < max) begin tick(); n++; end
      if (!bus.r_valid) check_eq("wait_rvalid_expired", 32'd0, 32'd1);
      t = cyc;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((rq.size() != 0 || ph != 0 || bus.busy) && n < max) begin tick(); n++; end
      check_eq("drain_done", 32'(bus.busy || rq.size() != 0), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, r, cnt;
      logic [DW-1:0] pushed[$];

      bus.s_valid = 0; bus.s_data = '0; bus.ma_done_i = 0;
      bus.ma_avg_i = '0; bus.r_ready = 0;
      #1 reset = 1'b1;
      #1;
      check_eq("rst_s_ready", 32'(bus.s_ready),     32'd1);
      check_eq("rst_level",   32'(bus.fifo_level),  32'd0);
      check_eq("rst_strobe",  32'(bus.ma_strobe_o), 32'd0);
      check_eq("rst_rvalid",  32'(bus.r_valid),     32'd0);
      check_eq("rst_busy",    32'(bus.busy),        32'd0);
      check_eq("rst_data",    32'(bus.ma_data_o),   32'd0);
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // 1: single sample, fixed average, latency
      fl_fix_en = 1; fl_fix = DW'(10'h0AA); fl_dly = 17;
      push_one(DW'(10'h155));
      wait_strobe(10, t);
      check_eq("t1_strobe_data", 32'(bus.ma_data_o), 32'h155);
      wait_rvalid(40, r);
      check_eq("t1_latency", 32'(r - t), 32'd19);
      check_eq("t1_r_data",  32'(bus.r_data), 32'h0AA);
      fl_fix_en = 0;

      // 2: fill FIFO while result is blocked
      strobe_log.delete();
      bus.s_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.s_data = DW'($urandom);
         if (i < 8) pushed.push_back(bus.s_data);
         tick();
         if (i == 7) begin
            check_eq("t2_level_full", 32'(bus.fifo_level), 32'd8);
            check_eq("t2_s_ready",    32'(bus.s_ready),    32'd0);
         end
      end
      bus.s_valid = 1'b0;
      check_eq("t2_ninth_dropped", 32'(bus.fifo_level), 32'd8);

      // 3: dispatch only on the drain edge
      cnt = 0;
      repeat (5) begin tick(); cnt += int'(bus.ma_strobe_o); end
      check_eq("t3_no_strobe_blocked", 32'(cnt), 32'd0);
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
      check_eq("t3_strobe_on_drain", 32'(bus.ma_strobe_o), 32'd1);
      check_eq("t3_rvalid_drained",  32'(bus.r_valid),     32'd0);
      wait_rvalid(40, r);
      cnt = 0;
      repeat (30) begin tick(); cnt += int'(bus.ma_strobe_o); end
      check_eq("t3_no_strobe_held", 32'(cnt), 32'd0);
      bus.r_ready = 1'b1;
      wait_idle(600);
      check_eq("t2_dispatch_count", 32'(strobe_log.size()), 32'd8);
      foreach (pushed[i])
         if (i < strobe_log.size()) check_eq("t2_order", 32'(strobe_log[i]), 32'(pushed[i]));

      // 4: filter never answers
      fl_dly = 0;
      push_one(DW'($urandom));
      push_one(DW'($urandom));
      wait_strobe(10, t);
      cnt = 0;
      while (!bus.timeout_o && cnt < 40) begin tick(); cnt++; end
      check_eq("t4_timeout_at", 32'(cyc - t), 32'(TO + 1));
      check_eq("t4_no_result", 32'(bus.r_valid), 32'd0);
      r = cyc;
      wait_strobe(5, t);
      check_eq("t4_next_dispatch", 32'(t - r), 32'd1);
      wait_idle(60);
      fl_dly = 17;

      // 5: reset during WAIT_DONE with samples queued
      push_one(DW'($urandom));
      wait_strobe(10, t);
      repeat (3) push_one(DW'($urandom));
      check_eq("t5_in_wait", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("t5_rst_level",  32'(bus.fifo_level),  32'd0);
      check_eq("t5_rst_busy",   32'(bus.busy),        32'd0);
      check_eq("t5_rst_data",   32'(bus.ma_data_o),   32'd0);
      check_eq("t5_rst_sready", 32'(bus.s_ready),     32'd1);
      repeat (2) tick();
      reset = 1'b0;
      cnt = 0;
      repeat (30) begin tick(); cnt += int'(bus.r_valid || bus.ma_strobe_o || bus.busy); end
      check_eq("t5_quiet_after_reset", 32'(cnt), 32'd0);

      // 6: stray done pulses, and done on the timeout cycle
      extra_done = 1; tick(); extra_done = 0; tick();
      check_eq("t6_idle_done_busy",   32'(bus.busy),    32'd0);
      check_eq("t6_idle_done_rvalid", 32'(bus.r_valid), 32'd0);
      done_on_strobe = 1; fl_dly = TO;
      push_one(DW'($urandom));
      wait_strobe(10, t);
      cnt = 0;
      while (!bus.r_valid && cnt < 40) begin tick(); cnt++; if (bus.timeout_o) r = -1; end
      check_eq("t6_done_wins_latency", 32'(cyc - t), 32'(TO + 2));
      done_on_strobe = 0; fl_dly = 17;
      tick();

      // randomized traffic
      fl_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         bus.s_valid = ($urandom_range(0, 1) == 1);
         bus.s_data  = DW'($urandom);
         bus.r_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      bus.s_valid = 1'b0;
      bus.r_ready = 1'b1;
      fl_rand = 0; fl_dly = 17;
      wait_idle(800);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ma_sample_streamer.md
Name: ma_sample_streamer

Overview:
Host-side driver for the moving-average filter's strobe interface.
- Buffers incoming samples in a small FIFO.
- Presents one sample at a time with a one-cycle strobe, holds the data stable, and waits for the filter's done strobe.
- Captures the averaged result into a valid/ready output register.
- Sits between the sample source (ADC or test pattern logic) and the averager core. Detects a stuck filter by timeout.

Parameters:
- DATA_W, 10, sample and result width.
- FIFO_AW, 3, log2 of FIFO depth (depth 8).
- TIMEOUT, 31, maximum cycles spent in WAIT_DONE before the sample is abandoned.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  DATA_W  sample to enqueue
- s_valid  in  1  sample-push request
- s_ready  out  1  FIFO can accept; equals !full
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..8
- ma_data_o  out  DATA_W  sample presented to the filter (registered)
- ma_strobe_o  out  1  one-cycle sample strobe to the filter (registered)
- ma_done_i  in  1  filter result strobe
- ma_avg_i  in  DATA_W  filter average; valid the cycle after ma_done_i
- r_data  out  DATA_W  captured average
- r_valid  out  1  result available
- r_ready  in  1  result consumer accepts
- busy  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse when a sample is abandoned

Behaviour:
- Reset values: all outputs 0, except s_ready = 1. FIFO is emptied; state = IDLE. A reset asserted mid-operation discards the in-flight sample and all queued samples.
- FIFO push occurs when s_valid && s_ready. The FIFO has no pass-through: when full, s_ready = 0 even if a pop happens in the same cycle. A simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged. Pointers wrap modulo depth.
- Dispatch condition: state == IDLE && FIFO non-empty && (!r_valid || r_ready).
- On the dispatch edge:
  - pop the FIFO head into ma_data_o;
  - set ma_strobe_o = 1;
  - clear the timer;
  - move to WAIT_DONE.
- ma_strobe_o is high for exactly the first WAIT_DONE cycle, then returns to 0.
- WAIT_DONE:
  - ma_data_o is held constant.
  - ma_done_i is ignored while ma_strobe_o = 1.
  - On ma_done_i = 1, go to CAPTURE.
  - Otherwise the timer increments each cycle. When timer == TIMEOUT, pulse timeout_o for one cycle, drop the sample (no result), and return to IDLE.
  - If ma_done_i arrives in the same cycle as timer == TIMEOUT, done wins and no timeout is signalled.
- CAPTURE (one cycle):
  - ma_data_o is still held, because the filter shifts the sample in during its done cycle.
  - r_data <= ma_avg_i; r_valid <= 1; go to IDLE.
- ma_data_o keeps its last value in IDLE.
- r_valid clears on r_valid && r_ready. The dispatch rule guarantees r_valid = 0 at capture, so a result is never overwritten.
- ma_done_i in IDLE or CAPTURE is ignored.
- Latency with the 16-tap filter:
  - strobe at cycle T;
  - done at T+17;
  - capture at T+18;
  - r_valid visible at T+19.
  - Back-to-back dispatch is then possible at T+19 (IDLE).
- State encoding: IDLE = 2'b00, WAIT_DONE = 2'b01, CAPTURE = 2'b11. An illegal state returns to IDLE.

Decomposition:
- Package ma_pkg: DATA_W = 10, FILTER_POWER = 4, default TIMEOUT, state encoding constants.
- One sub-module, ma_sync_fifo: parameterised by DATA_W/FIFO_AW, single clock, async reset. Ports: push, pop, din, dout, full, empty, level.
- The streamer FSM, timer and result register live in the top module.

Test Plan:
1. Push 0x155 into the idle block with a behavioural filter model (done 17 cycles after strobe, avg = 0x0AA the next cycle) -> ma_strobe_o high for exactly 1 cycle with ma_data_o = 0x155; ma_data_o held through capture; r_valid = 1 with r_data = 0x0AA at T+19.
2. Push 9 samples back-to-back with no dispatch possible (r_valid held with r_ready = 0) -> s_ready = 0 at fifo_level = 8; the 9th sample is not accepted; samples dispatch in FIFO order once r_ready = 1.
3. Hold r_ready = 0 after the first result -> no second ma_strobe_o until r_ready pulses. Dispatch occurs on the same edge as the drain.
4. Filter model never asserts done -> timeout_o pulses once exactly TIMEOUT+1 cycles after strobe; r_valid stays 0; the next queued sample dispatches.
5. Assert reset during WAIT_DONE with 3 samples queued -> all outputs 0, fifo_level = 0, no r_valid after reset release, and a late done is ignored.
6. Pulse ma_done_i while idle, and in the same cycle as ma_strobe_o -> no capture and no state change. Then a done coinciding with timer == TIMEOUT -> result captured, timeout_o stays 0.
